// File: rtl/common.sv
// Shared types for the RV32 front end and pipeline bundles.
// Carries the branch predictor type codes and history snapshot.
package common;

    typedef enum logic [1:0] {
        COND = 2'd0,
        JUMP = 2'd1,
        CALL = 2'd2,
        RET  = 2'd3
    } btb_type_e;

    localparam int BPU_GHR_W    = 8;
    localparam int BPU_RAS_PTR_W = 2;

    typedef struct packed {
        logic [BPU_RAS_PTR_W-1:0] ras_ptr;
        logic [BPU_GHR_W-1:0]     ghr;
    } bpu_meta_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        bpu_meta_t   bpu_meta;
    } id_ex_type;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_result;
        bpu_meta_t   bpu_meta;
    } ex_mem_type;

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack with pointer restore.
// Restore replaces the pointer before any same-cycle push or pop.
module return_addr_stack #(
    parameter int PC_W  = 32,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [PC_W-1:0]  push_addr,
    input  logic             restore,
    input  logic [PTR_W-1:0] restore_ptr,
    output logic [PC_W-1:0]  top,
    output logic [PTR_W-1:0] ptr,
    output logic             empty
);

    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] ONE  = (PTR_W+1)'(1);

    logic [PC_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W-1:0] base;
    logic [PTR_W-1:0] top_idx;

    assign base    = restore ? restore_ptr : ptr_q;
    assign top_idx = ptr_q - PTR_W'(1);
    assign top     = mem[top_idx];
    assign ptr     = ptr_q;
    assign empty   = (count_q == '0);

    // Count is not carried in the snapshot, so a restore keeps it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else if (push) begin
            ptr_q <= base + PTR_W'(1);
            if (count_q != FULL)
                count_q <= count_q + ONE;
        end else if (pop && !empty) begin
            ptr_q   <= base - PTR_W'(1);
            count_q <= count_q - ONE;
        end else if (restore) begin
            ptr_q <= restore_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && push)
            mem[base] <= push_addr;
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Front-end predictor: gshare PHT, direct-mapped BTB and RAS.
// Predicts from registered state; EX updates train and repair.
module branch_predict_unit
    import common::*;
#(
    parameter int         PC_W        = 32,
    parameter int         GHR_W       = 8,
    parameter int         BTB_ENTRIES = 16,
    parameter int         RAS_DEPTH   = 4,
    parameter logic [1:0] CNT_INIT    = 2'b01,
    localparam int        META_W      = GHR_W + $clog2(RAS_DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fetch_valid,
    input  logic [PC_W-1:0]   fetch_pc,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_target,
    output logic [META_W-1:0] pred_meta,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  btb_type_e         upd_type,
    input  logic              upd_short,
    input  logic              upd_taken,
    input  logic [PC_W-1:0]   upd_target,
    input  logic              upd_mispredict,
    input  logic [META_W-1:0] upd_meta
);

    localparam int BI    = $clog2(BTB_ENTRIES);
    localparam int TAG_W = PC_W - BI - 1;
    localparam int RP_W  = $clog2(RAS_DEPTH);
    localparam int PHT_N = 2 ** GHR_W;

    logic [GHR_W-1:0] ghr;
    logic [1:0]       pht [PHT_N];

    logic             btb_valid  [BTB_ENTRIES];
    logic [TAG_W-1:0] btb_tag    [BTB_ENTRIES];
    logic [PC_W-1:0]  btb_target [BTB_ENTRIES];
    btb_type_e        btb_type   [BTB_ENTRIES];
    logic             btb_short  [BTB_ENTRIES];

    logic [BI-1:0]    f_bi;
    logic [TAG_W-1:0] f_tag;
    logic [GHR_W-1:0] f_pi;
    logic             f_hit;
    btb_type_e        f_type;
    logic [PC_W-1:0]  f_link;

    logic [BI-1:0]    u_bi;
    logic [TAG_W-1:0] u_tag;
    logic [GHR_W-1:0] u_ghr;
    logic [RP_W-1:0]  u_ptr;
    logic [GHR_W-1:0] u_pi;
    logic [PC_W-1:0]  u_link;
    logic             repair;

    logic             ras_push;
    logic             ras_pop;
    logic             ras_restore;
    logic [PC_W-1:0]  ras_addr;
    logic [PC_W-1:0]  ras_top;
    logic [RP_W-1:0]  ras_ptr;
    logic             ras_empty;

    logic             unused_bits;

    assign unused_bits = ^{fetch_pc[0], upd_pc[0]};

    assign f_bi   = fetch_pc[BI:1];
    assign f_tag  = fetch_pc[PC_W-1:BI+1];
    assign f_pi   = fetch_pc[GHR_W:1] ^ ghr;
    assign f_hit  = btb_valid[f_bi] && (btb_tag[f_bi] == f_tag);
    assign f_type = btb_type[f_bi];
    assign f_link = fetch_pc + (btb_short[f_bi] ? PC_W'(2) : PC_W'(4));

    assign u_bi   = upd_pc[BI:1];
    assign u_tag  = upd_pc[PC_W-1:BI+1];
    assign u_ghr  = upd_meta[GHR_W-1:0];
    assign u_ptr  = upd_meta[META_W-1:GHR_W];
    assign u_pi   = upd_pc[GHR_W:1] ^ u_ghr;
    assign u_link = upd_pc + (upd_short ? PC_W'(2) : PC_W'(4));
    assign repair = upd_valid && upd_mispredict;

    assign pred_meta = {ras_ptr, ghr};

    always_comb begin
        pred_taken  = 1'b0;
        pred_target = '0;
        if (f_hit) begin
            pred_target = btb_target[f_bi];
            unique case (f_type)
                COND: pred_taken = pht[f_pi][1];
                JUMP,
                CALL: pred_taken = 1'b1;
                RET: begin
                    pred_taken = 1'b1;
                    if (!ras_empty)
                        pred_target = ras_top;
                end
            endcase
        end
    end

    // Repair replays the resolving instruction's own push/pop.
    always_comb begin
        ras_push    = 1'b0;
        ras_pop     = 1'b0;
        ras_restore = 1'b0;
        ras_addr    = f_link;
        if (repair) begin
            ras_restore = 1'b1;
            ras_push    = (upd_type == CALL);
            ras_pop     = (upd_type == RET);
            ras_addr    = u_link;
        end else if (fetch_valid && f_hit) begin
            ras_push = (f_type == CALL);
            ras_pop  = (f_type == RET) && !ras_empty;
        end
    end

    return_addr_stack #(
        .PC_W  (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .reset_n     (reset_n),
        .push        (ras_push),
        .pop         (ras_pop),
        .push_addr   (ras_addr),
        .restore     (ras_restore),
        .restore_ptr (u_ptr),
        .top         (ras_top),
        .ptr         (ras_ptr),
        .empty       (ras_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset_n)
            ghr <= '0;
        else if (repair)
            ghr <= (upd_type == COND) ?
                   {u_ghr[GHR_W-2:0], upd_taken} : u_ghr;
        else if (fetch_valid && f_hit && f_type == COND)
            ghr <= {ghr[GHR_W-2:0], pred_taken};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < PHT_N; i++)
                pht[i] <= CNT_INIT;
        end else if (upd_valid && upd_type == COND) begin
            if (upd_taken && pht[u_pi] != 2'b11)
                pht[u_pi] <= pht[u_pi] + 2'd1;
            else if (!upd_taken && pht[u_pi] != 2'b00)
                pht[u_pi] <= pht[u_pi] - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++)
                btb_valid[i] <= 1'b0;
        end else if (upd_valid && upd_taken) begin
            btb_valid[u_bi] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && upd_valid && upd_taken) begin
            btb_tag[u_bi]    <= u_tag;
            btb_target[u_bi] <= upd_target;
            btb_type[u_bi]   <= upd_type;
            btb_short[u_bi]  <= upd_short;
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: vector table plus
// hand sequences for PHT sweep, reset, GHR repair and RAS.
module tb_branch_predict_unit;
    import common::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [9:0]  pred_meta;
    logic        upd_valid;
    logic [31:0] upd_pc;
    btb_type_e   upd_type;
    logic        upd_short;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;
    logic [9:0]  upd_meta;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    branch_predict_unit dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .fetch_valid    (fetch_valid),
        .fetch_pc       (fetch_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .pred_meta      (pred_meta),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_type       (upd_type),
        .upd_short      (upd_short),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_mispredict (upd_mispredict),
        .upd_meta       (upd_meta)
    );

    typedef struct {
        logic        fv;
        logic [31:0] pc;
        logic        uv;
        btb_type_e   ut;
        logic        utk;
        logic [31:0] utg;
        logic        um;
        logic [9:0]  umeta;
        logic        etk;
        logic [31:0] etg;
        logic [9:0]  emeta;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t v(logic fv, logic [31:0] pc,
                               logic uv, btb_type_e ut,
                               logic utk, logic [31:0] utg,
                               logic um, logic [9:0] umeta,
                               logic etk, logic [31:0] etg,
                               logic [9:0] emeta);
        vec_t r;
        r.fv = fv; r.pc = pc; r.uv = uv; r.ut = ut;
        r.utk = utk; r.utg = utg; r.um = um; r.umeta = umeta;
        r.etk = etk; r.etg = etg; r.emeta = emeta;
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act,
                       logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fetch_valid    = 1'b0;
        fetch_pc       = 32'h0;
        upd_valid      = 1'b0;
        upd_pc         = 32'h0;
        upd_type       = COND;
        upd_short      = 1'b0;
        upd_taken      = 1'b0;
        upd_target     = 32'h0;
        upd_mispredict = 1'b0;
        upd_meta       = 10'h0;
    endtask

    task automatic upd(logic [31:0] pc, btb_type_e t, logic s,
                       logic tk, logic [31:0] tg, logic m,
                       logic [9:0] meta);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_type       = t;
        upd_short      = s;
        upd_taken      = tk;
        upd_target     = tg;
        upd_mispredict = m;
        upd_meta       = meta;
    endtask

    task automatic fetch(logic fv, logic [31:0] pc);
        fetch_valid = fv;
        fetch_pc    = pc;
    endtask

    task automatic chk_pred(string nm, logic tk, logic [31:0] tg,
                            logic [9:0] meta);
        #1;
        chk({nm, ".taken"}, 32'(pred_taken), 32'(tk));
        chk({nm, ".target"}, pred_target, tg);
        chk({nm, ".meta"}, 32'(pred_meta), 32'(meta));
    endtask

    logic [31:0] call_pc [5];
    logic [31:0] call_rt [5];
    logic        call_sh [5];

    initial begin
        tbl[0]  = v(0, 32'h200, 0, COND, 0, 0, 0, 0, 0, 32'h0, 10'h000);
        tbl[1]  = v(1, 32'h200, 1, COND, 1, 32'h180, 1, 10'h000,
                    0, 32'h0, 10'h000);
        tbl[2]  = v(0, 32'h200, 0, COND, 0, 0, 0, 0, 0, 32'h180, 10'h001);
        tbl[3]  = v(0, 32'h200, 1, COND, 1, 32'h180, 0, 10'h001,
                    0, 32'h180, 10'h001);
        tbl[4]  = v(0, 32'h200, 0, COND, 0, 0, 0, 0, 1, 32'h180, 10'h001);
        tbl[5]  = v(0, 32'h200, 1, COND, 1, 32'h180, 0, 10'h001,
                    1, 32'h180, 10'h001);
        tbl[6]  = v(0, 32'h200, 1, COND, 1, 32'h180, 0, 10'h001,
                    1, 32'h180, 10'h001);
        tbl[7]  = v(0, 32'h200, 1, COND, 0, 32'hDEAD0, 0, 10'h001,
                    1, 32'h180, 10'h001);
        tbl[8]  = v(0, 32'h200, 0, COND, 0, 0, 0, 0, 1, 32'h180, 10'h001);
        tbl[9]  = v(0, 32'h200, 1, COND, 0, 32'hDEAD0, 0, 10'h001,
                    1, 32'h180, 10'h001);
        tbl[10] = v(0, 32'h200, 0, COND, 0, 0, 0, 0, 0, 32'h180, 10'h001);
        tbl[11] = v(0, 32'h200, 1, COND, 0, 32'hDEAD0, 0, 10'h001,
                    0, 32'h180, 10'h001);
        tbl[12] = v(0, 32'h200, 1, COND, 0, 32'hDEAD0, 0, 10'h001,
                    0, 32'h180, 10'h001);
        tbl[13] = v(0, 32'h200, 1, COND, 1, 32'h180, 0, 10'h001,
                    0, 32'h180, 10'h001);
        tbl[14] = v(0, 32'h200, 0, COND, 0, 0, 0, 0, 0, 32'h180, 10'h001);
        tbl[15] = v(0, 32'h200, 1, COND, 1, 32'h180, 0, 10'h05A,
                    0, 32'h180, 10'h001);
        tbl[16] = v(0, 32'h200, 1, JUMP, 1, 32'h700, 1, 10'h05A,
                    0, 32'h180, 10'h001);
        tbl[17] = v(1, 32'h200, 1, COND, 0, 32'hDEAD0, 1, 10'h05A,
                    1, 32'h180, 10'h05A);
        tbl[18] = v(1, 32'h200, 0, COND, 0, 0, 0, 0, 0, 32'h180, 10'h0B4);
        tbl[19] = v(0, 32'h200, 0, COND, 0, 0, 0, 0, 0, 32'h180, 10'h068);
        tbl[20] = v(0, 32'h100, 0, COND, 0, 0, 0, 0, 0, 32'h0, 10'h068);

        call_pc[0] = 32'h302; call_sh[0] = 0; call_rt[0] = 32'h306;
        call_pc[1] = 32'h344; call_sh[1] = 0; call_rt[1] = 32'h348;
        call_pc[2] = 32'h386; call_sh[2] = 1; call_rt[2] = 32'h388;
        call_pc[3] = 32'h3C8; call_sh[3] = 0; call_rt[3] = 32'h3CC;
        call_pc[4] = 32'h40A; call_sh[4] = 0; call_rt[4] = 32'h40E;

        // Reset with update and fetch traffic present.
        idle();
        reset_n = 1'b0;
        upd(32'h300, CALL, 0, 1, 32'h1000, 1, 10'h0FF);
        fetch(1, 32'h300);
        #1;
        tick();
        tick();
        reset_n = 1'b1;
        idle();
        fetch(1, 32'h100);
        chk_pred("reset_fetch", 0, 32'h0, 10'h000);
        tick();

        // Every PHT entry at its reset value via the prediction path.
        idle();
        upd(32'h500, COND, 0, 1, 32'h580, 0, 10'h000);
        tick();
        upd(32'h500, COND, 0, 0, 32'h580, 0, 10'h000);
        tick();
        for (int i = 0; i <= 256; i++) begin
            logic [7:0] eg;
            idle();
            fetch(1, 32'h500);
            if (i < 256)
                upd(32'h602, JUMP, 0, 1, 32'h700, 1, 10'(i));
            eg = (i == 0) ? 8'h00 : 8'(i - 1);
            #1;
            chk($sformatf("pht_sweep[%0d].taken", i),
                32'(pred_taken), 32'h0);
            chk($sformatf("pht_sweep[%0d].ghr", i),
                32'(pred_meta), 32'(eg));
            if (i == 0)
                chk("pht_sweep.target", pred_target, 32'h580);
            tick();
        end

        // Reset in the same cycle as a mispredicted update.
        idle();
        reset_n = 1'b0;
        upd(32'h200, COND, 0, 1, 32'h180, 1, 10'h3FF);
        fetch(1, 32'h500);
        tick();
        reset_n = 1'b1;
        idle();
        fetch(1, 32'h500);
        chk_pred("rst_upd_500", 0, 32'h0, 10'h000);
        fetch(1, 32'h200);
        #1;
        chk("rst_upd_200.taken", 32'(pred_taken), 32'h0);
        fetch(1, 32'h602);
        #1;
        chk("rst_upd_602.taken", 32'(pred_taken), 32'h0);
        tick();

        for (int i = 0; i < 21; i++) begin
            idle();
            fetch(tbl[i].fv, tbl[i].pc);
            if (tbl[i].uv)
                upd(tbl[i].pc == 32'h200 && tbl[i].ut == JUMP ?
                    32'h602 : tbl[i].pc,
                    tbl[i].ut, 0, tbl[i].utk, tbl[i].utg,
                    tbl[i].um, tbl[i].umeta);
            chk_pred($sformatf("vec[%0d]", i),
                     tbl[i].etk, tbl[i].etg, tbl[i].emeta);
            tick();
        end

        // CALL trained by a mispredict pushes its return address.
        idle();
        fetch(0, 32'h300);
        upd(32'h300, CALL, 0, 1, 32'h1000, 1, 10'h000);
        tick();
        idle();
        fetch(0, 32'h300);
        chk_pred("call300", 1, 32'h1000, 10'h100);
        tick();
        idle();
        upd(32'h400, RET, 0, 1, 32'hABC, 0, 10'h000);
        tick();
        idle();
        fetch(1, 32'h400);
        chk_pred("ret400", 1, 32'h304, 10'h100);
        tick();
        idle();
        fetch(0, 32'h400);
        chk_pred("ret400_empty", 1, 32'hABC, 10'h000);
        tick();

        // Five nested calls into a four-deep stack, then returns.
        for (int i = 0; i < 5; i++) begin
            idle();
            upd(call_pc[i], CALL, call_sh[i], 1,
                32'h2000 + 32'(i) * 32'h10, 0, 10'h000);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            idle();
            fetch(1, call_pc[i]);
            chk_pred($sformatf("nest_call[%0d]", i), 1,
                     32'h2000 + 32'(i) * 32'h10,
                     10'({2'(i), 8'h00}));
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            idle();
            fetch(1, 32'h400);
            chk_pred($sformatf("nest_ret[%0d]", i), 1,
                     call_rt[4-i],
                     10'({2'(1 - i), 8'h00}));
            tick();
        end
        idle();
        fetch(1, 32'h400);
        chk_pred("nest_ret_empty", 1, 32'hABC, 10'h100);
        tick();

        idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised front-end branch predictor for the 5-stage RV32 pipeline, replacing the direction-only gshare. It combines a gshare pattern history table, a direct-mapped branch target buffer and a return-address stack. Together these give a next-PC guess (direction and target) in the same cycle as the fetch PC. Execute returns resolved outcomes to train the tables and to repair speculative history on a mispredict.

## Interface
- `PC_W`, 32, PC/target width.
- `GHR_W`, 8, global history bits; PHT has 2^GHR_W 2-bit counters.
- `BTB_ENTRIES`, 16, BTB entries, power of 2, direct-mapped.
- `RAS_DEPTH`, 4, return-address stack entries, power of 2.
- `CNT_INIT`, 2'b01, PHT counter reset value (weakly not-taken).
- `clk  in  1  clock.`
- `reset_n  in  1  synchronous, active-low reset.`
- `fetch_valid  in  1  fetch_pc is a real fetch this cycle (low during stall).`
- `fetch_pc  in  PC_W  current fetch address.`
- `pred_taken  out  1  redirect fetch to pred_target.`
- `pred_target  out  PC_W  predicted target.`
- `pred_meta  out  META_W  {ras_ptr, ghr} snapshot before this fetch's update; pipeline carries it to EX. META_W = GHR_W + $clog2(RAS_DEPTH).`
- `upd_valid  in  1  resolved control-flow instruction in EX.`
- `upd_pc  in  PC_W  its PC.`
- `upd_type  in  2  btb_type_e: COND, JUMP, CALL, RET.`
- `upd_short  in  1  instruction was compressed (2 bytes).`
- `upd_taken  in  1  actual direction (1 for JUMP/CALL/RET).`
- `upd_target  in  PC_W  actual target.`
- `upd_mispredict  in  1  direction or target was wrong; EX flushes.`
- `upd_meta  in  META_W  pred_meta returned with the instruction.`

## Operation
- PHT index: `fetch_pc[GHR_W:1] ^ ghr`. BTB index: `fetch_pc[$clog2(BTB_ENTRIES):1]`. Tag: the remaining upper bits.
- BTB entry fields: valid, tag, target, type, short.
- Prediction is combinational from registered state:
  - BTB miss -> pred_taken=0.
  - COND hit -> pred_taken = PHT counter MSB, target = BTB target.
  - JUMP/CALL hit -> pred_taken = 1.
  - RET hit -> pred_taken = 1; target = RAS top if non-empty, else BTB target.
- Speculative state update, only when fetch_valid:
  - COND hit: `ghr <= {ghr[GHR_W-2:0], pred_taken}`.
  - CALL hit: push `fetch_pc + (short ? 2 : 4)`.
  - RET hit on non-empty RAS: pop.
- RAS is circular. A push when full overwrites the oldest entry; count saturates at RAS_DEPTH. A pop when empty leaves pointer and count unchanged.
- Training on upd_valid:
  - COND: PHT[`upd_pc[GHR_W:1] ^ upd_meta.ghr`] saturating +1 if taken, -1 if not (clamps at 0 and 3).
  - Any taken type: BTB entry written (allocate or replace) with tag, target, type and short.
  - Not-taken COND: BTB entry untouched.
- Repair on upd_valid & upd_mispredict:
  - COND: `ghr <= {upd_meta.ghr[GHR_W-2:0], upd_taken}`; otherwise `ghr <= upd_meta.ghr`.
  - RAS pointer restored from upd_meta, then the CALL push or RET pop of the resolving instruction is re-applied.
  - Repair overrides any same-cycle speculative update from fetch.

## Timing
- Prediction: 0-cycle latency, combinational from fetch_pc.
- Table and GHR writes take effect at the next posedge. A fetch in the same cycle as an update sees pre-update state.
- Update and fetch hitting the same BTB/PHT index in one cycle: the update write wins; the fetch prediction uses the old value.
- Reset (synchronous, any cycle, including mid-update):
  - ghr=0, all PHT = CNT_INIT, all BTB valid=0, RAS ptr=0, count=0.
  - With state reset, outputs read pred_taken=0, pred_target=0, pred_meta=0.
- fetch_valid=0 (stall): outputs still computed, no state changes from the fetch side. Updates still apply.

## Structure
- Shared package `common`: `btb_type_e` (COND=0, JUMP=1, CALL=2, RET=3) and the `bpu_meta_t` packed struct {ras_ptr, ghr}. `id_ex_type` and `ex_mem_type` gain a `bpu_meta_t` field.
- One sub-module, `return_addr_stack`: push, pop and restore (ptr, count) with circular storage. PHT and BTB stay inline as flop arrays.

## Test plan
- Reset, then fetch 0x100 -> pred_taken=0, pred_meta=0. Every PHT entry reads 2'b01 through the prediction path.
- COND at 0x200 resolved taken to 0x180 three times (mispredict on the first) -> fetch 0x200 gives pred_taken=1, target 0x180. The counter saturates at 3 after a 4th taken.
- CALL at 0x300 (short=0), then RET hit at 0x400 -> pred_target=0x304. Five nested calls with RAS_DEPTH=4 -> the oldest is overwritten, and four returns predict in LIFO order.
- COND predicted taken with ghr=8'h5A, resolved not-taken with mispredict -> next-cycle ghr=8'hB4 regardless of the same-cycle fetch hit.
- Update to 0x200 and fetch of 0x200 in the same cycle -> fetch returns the old prediction; the following cycle returns the new one.
- reset_n low in the same cycle as an upd_valid mispredict -> all state at reset values next cycle, no table write.
